mips_fetch_pc_unit: RTL and testbench
=====================================

Name: mips_fetch_pc_unit

Overview:
- Sequential fetch and PC stage of the single-cycle MIPS core.
- Owns the PC register and the instruction-memory request handshake.
- Holds the fetched instruction in an instruction register (IR). The IR feeds opcode/funct/fmt4 to the main decoder, and instr[25:0] to the regfile and immediate paths.
- Consumes the decoder's Jump/Branch/NEqual/Jr/Bclt outputs plus ALU zero and the FP condition flag to select the next PC, then commits one instruction per EXEC cycle.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word aligned).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- imem_req  output  1  instruction fetch request.
- imem_addr  output  32  fetch address, equal to pc.
- imem_ready  input  1  fetch data valid this cycle; sampled only while imem_req=1.
- imem_rdata  input  32  fetched instruction word.
- instr  output  32  IR contents.
- instr_valid  output  1  high in EXEC; decoder and datapath outputs meaningful.
- pc  output  32  address of the current instruction.
- pc_plus4  output  32  pc+4, used as the jal link value.
- stall  input  1  datapath (e.g. dmem busy) holds EXEC.
- jump, branch, nequal, jr, bclt  input  1 each  from the decoder.
- alu_zero  input  1  ALU zero flag.
- fp_cond  input  1  FP compare condition flag.
- rs_data  input  32  GPR[rs], the jr target.
- addr_err  output  1  sticky: misaligned jr target seen.
- retired  output  CNT_W  count of committed instructions.

Behaviour:
- Reset (rst high at a clock edge):
  - state<=FETCH, pc<=RESET_PC, instr<=0, addr_err<=0, retired<=0.
  - While rst is high, imem_req=0 and instr_valid=0 (gated).
  - The first request is issued in the first cycle after rst is deasserted.
  - Reset mid-fetch or mid-EXEC abandons the instruction: no commit, no counter increment. The memory must drop any pending request on rst.
- States:
  - FETCH:
    - imem_req=1 and imem_addr=pc, held stable until imem_ready.
    - On imem_ready: instr<=imem_rdata, go to EXEC.
    - Zero-wait memory (ready in the same cycle as req) is legal.
  - EXEC:
    - instr_valid=1, imem_req=0.
    - If stall=1: stay in EXEC; pc, instr and retired are unchanged.
    - Else: pc<=next_pc, retired<=retired+1 (wraps to 0 at 2^CNT_W), go to FETCH.
- Throughput: minimum 2 cycles per instruction.
- next_pc priority, highest first:
  1. jr: {rs_data[31:2],2'b00}. If rs_data[1:0]!=0, set addr_err (sticky until rst).
  2. jump: {pc_plus4[31:28], instr[25:0], 2'b00}.
  3. bclt: taken if fp_cond==instr[16]; target = pc_plus4 + (sign_ext(instr[15:0])<<2).
  4. branch: taken if alu_zero XOR nequal; same target as bclt.
  5. Otherwise pc_plus4.
- Arithmetic is modulo 2^32; a carry out of bit 31 is discarded.
- A branch or jump to its own address is legal (infinite loop).
- pc_plus4 is combinational pc+4.
- Control inputs are sampled only in a non-stalled EXEC cycle and are ignored elsewhere.
- imem_ready outside FETCH is ignored; instr is unchanged.

Test Plan:
- Reset with RESET_PC=0x100 and zero-wait imem: first req at addr 0x100 in the cycle after rst falls. Sequential nops give pc 0x100, 0x104, 0x108 every 2 cycles; retired=3 after 6 cycles.
- Imem ready delayed 3 cycles at pc=0x200: imem_req and imem_addr=0x200 held stable for 4 cycles; instr_valid asserts the cycle after ready.
- beq at pc=0x40, imm=0xFFFE, alu_zero=1, nequal=0: next pc=0x3C. Same instruction with nequal=1 (bne): next pc=0x44.
- j at pc=0x8000_0010, instr[25:0]=0x0000100: next pc=0x8000_0400. jr with rs_data=0x1003: pc=0x1000 and addr_err=1, still set after 5 more instructions.
- bc1t (instr[16]=1) with fp_cond=1, imm=4: pc advances +20. bc1f with fp_cond=1: pc+4.
- Stall held 5 cycles in EXEC: pc, instr and retired frozen. rst asserted mid-FETCH: pc=RESET_PC, retired=0, no commit; late imem_ready is ignored.

Source files
------------

// File: rtl/mips_fetch_pc_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit (master) and imem (slave).
interface mips_fetch_pc_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );
endinterface

// File: rtl/mips_fetch_pc_unit.sv
// Fetch/PC stage: owns PC and IR, runs the FETCH/EXEC handshake and selects the next PC.
module mips_fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned CNT_W    = 32
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   mips_fetch_pc_unit_if.master        io_imem,
   output logic [31:0]                 o_instr,
   output logic                        o_instr_valid,
   output logic [31:0]                 o_pc,
   output logic [31:0]                 o_pc_plus4,
   input  logic                        i_stall,
   input  logic                        i_jump,
   input  logic                        i_branch,
   input  logic                        i_nequal,
   input  logic                        i_jr,
   input  logic                        i_bclt,
   input  logic                        i_alu_zero,
   input  logic                        i_fp_cond,
   input  logic [31:0]                 i_rs_data,
   output logic                        o_addr_err,
   output logic [CNT_W-1:0]            o_retired
);

   typedef enum logic {StFetch, StExec} state_e;

   state_e           r_state, w_state_next;
   logic [31:0]      r_pc, r_instr;
   logic             r_addr_err;
   logic [CNT_W-1:0] r_retired;

   logic [31:0]      w_pc_plus4, w_br_target, w_next_pc;
   logic             w_fetch_done, w_commit;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= StFetch;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StFetch: if (io_imem.imem_ready) w_state_next = StExec;
         StExec:  if (!i_stall)           w_state_next = StFetch;
         default: w_state_next = StFetch;
      endcase
   end

   // Handshake outputs are forced low while reset is held.
   always_comb begin
      io_imem.imem_req  = (r_state == StFetch) && !i_rst;
      io_imem.imem_addr = r_pc;
      o_instr_valid     = (r_state == StExec) && !i_rst;
   end

   assign w_fetch_done = (r_state == StFetch) && io_imem.imem_ready;
   assign w_commit     = (r_state == StExec) && !i_stall;

   assign w_pc_plus4  = r_pc + 32'd4;
   assign w_br_target = w_pc_plus4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

   always_comb begin
      w_next_pc = w_pc_plus4;
      if (i_jr)                                   w_next_pc = {i_rs_data[31:2], 2'b00};
      else if (i_jump)                            w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
      else if (i_bclt && (i_fp_cond == r_instr[16])) w_next_pc = w_br_target;
      else if (i_branch && (i_alu_zero ^ i_nequal))  w_next_pc = w_br_target;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pc       <= RESET_PC;
         r_instr    <= 32'd0;
         r_addr_err <= 1'b0;
         r_retired  <= '0;
      end else begin
         if (w_fetch_done) r_instr <= io_imem.imem_rdata;
         if (w_commit) begin
            r_pc      <= w_next_pc;
            r_retired <= r_retired + CNT_W'(1);
            if (i_jr && (i_rs_data[1:0] != 2'b00)) r_addr_err <= 1'b1;
         end
      end
   end

   assign o_pc       = r_pc;
   assign o_pc_plus4 = w_pc_plus4;
   assign o_instr    = r_instr;
   assign o_addr_err = r_addr_err;
   assign o_retired  = r_retired;

endmodule

// File: tb/tb_mips_fetch_pc_unit.sv
// Directed bench for mips_fetch_pc_unit with a transaction-level reference model.
module tb_mips_fetch_pc_unit;

   localparam logic [31:0] RPC = 32'h0000_0100;

   logic        clk;
   logic        rst;
   logic [31:0] instr, pc, pc_plus4, rs_data;
   logic        instr_valid, stall, jump, branch, nequal, jr, bclt, alu_zero, fp_cond, addr_err;
   logic [31:0] retired;

   mips_fetch_pc_unit_if imem ();

   mips_fetch_pc_unit #(.RESET_PC(RPC), .CNT_W(32)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .io_imem       (imem.master),
      .o_instr       (instr),
      .o_instr_valid (instr_valid),
      .o_pc          (pc),
      .o_pc_plus4    (pc_plus4),
      .i_stall       (stall),
      .i_jump        (jump),
      .i_branch      (branch),
      .i_nequal      (nequal),
      .i_jr          (jr),
      .i_bclt        (bclt),
      .i_alu_zero    (alu_zero),
      .i_fp_cond     (fp_cond),
      .i_rs_data     (rs_data),
      .o_addr_err    (addr_err),
      .o_retired     (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Model: architectural state plus which phase of the instruction we expect.
   logic [31:0] m_pc, m_instr, m_retired;
   logic        m_addr_err, m_req, m_valid;
   logic        chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] iw,
                                              input logic c_jr, input logic c_jmp,
                                              input logic c_bclt, input logic c_br,
                                              input logic c_neq, input logic c_zero,
                                              input logic c_fp, input logic [31:0] rs);
      logic [31:0] p4;
      int          off;
      p4  = cur + 32'd4;
      off = int'($signed(iw[15:0])) * 4;
      if (c_jr)                         return rs & 32'hFFFF_FFFC;
      if (c_jmp)                        return {p4[31:28], iw[25:0], 2'b00};
      if (c_bclt && (c_fp == iw[16]))   return p4 + 32'(off);
      if (c_br && (c_zero != c_neq))    return p4 + 32'(off);
      return p4;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("imem_req", imem.imem_req, m_req);
         if (m_req) chk("imem_addr", imem.imem_addr, m_pc);
         chk("instr_valid", instr_valid, m_valid);
         chk("pc", pc, m_pc);
         chk("pc_plus4", pc_plus4, m_pc + 32'd4);
         chk("instr", instr, m_instr);
         chk("addr_err", addr_err, m_addr_err);
         chk("retired", retired, m_retired);
      end
   end

   task automatic clear_ctrl();
      {jump, branch, nequal, jr, bclt, alu_zero, fp_cond} = '0;
      rs_data = 32'd0;
   endtask

   // One instruction: lat wait cycles before ready, stl stall cycles in EXEC, then commit.
   task automatic do_instr(input logic [31:0] iw, input int lat, input int stl,
                           input logic c_jr, input logic c_jmp, input logic c_bclt,
                           input logic c_br, input logic c_neq, input logic c_zero,
                           input logic c_fp, input logic [31:0] rs);
      for (int k = 0; k <= lat; k++) begin
         imem.imem_ready = (k == lat);
         imem.imem_rdata = (k == lat) ? iw : 32'hDEAD_BEEF;
         @(posedge clk); #1;
      end
      m_instr = iw;
      m_req   = 1'b0;
      m_valid = 1'b1;
      for (int k = 0; k < stl; k++) begin
         // Noise that must be ignored while stalled in EXEC.
         stall = 1'b1;
         imem.imem_ready = 1'b1;
         imem.imem_rdata = 32'hBAD0_0000 | 32'(k);
         jr = 1'b1;
         rs_data = 32'h0000_0DE3;
         @(posedge clk); #1;
      end
      stall = 1'b0;
      imem.imem_ready = 1'b0;
      {jr, jump, bclt, branch, nequal, alu_zero, fp_cond} =
         {c_jr, c_jmp, c_bclt, c_br, c_neq, c_zero, c_fp};
      rs_data = rs;
      @(posedge clk); #1;
      if (c_jr && (rs[1:0] != 2'b00)) m_addr_err = 1'b1;
      m_pc = model_next(m_pc, iw, c_jr, c_jmp, c_bclt, c_br, c_neq, c_zero, c_fp, rs);
      m_retired = m_retired + 32'd1;
      m_req   = 1'b1;
      m_valid = 1'b0;
      clear_ctrl();
   endtask

   task automatic nop(input int lat);
      do_instr(32'd0, lat, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0);
   endtask

   task automatic jr_to(input logic [31:0] tgt);
      do_instr(32'h0000_0008, 0, 0, 1, 0, 0, 0, 0, 0, 0, tgt);
   endtask

   initial begin
      rst = 1'b1;
      stall = 1'b0;
      clear_ctrl();
      imem.imem_ready = 1'b0;
      imem.imem_rdata = 32'd0;
      m_pc = RPC; m_instr = 32'd0; m_retired = 32'd0;
      m_addr_err = 1'b0; m_req = 1'b0; m_valid = 1'b0;

      @(posedge clk); #1;
      chk_en = 1'b1;
      chk("reset_pc", pc, 32'h100);
      chk("reset_retired", retired, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      m_req = 1'b1;

      // Sequential nops, zero-wait memory.
      nop(0); nop(0); nop(0);
      chk("seq_pc", pc, 32'h10C);
      chk("seq_retired", retired, 3);

      // jr wins over jump/branch set in the same cycle.
      do_instr(32'h0000_0008, 0, 0, 1, 1, 0, 1, 0, 1, 0, 32'h0000_0200);
      chk("jr_prio_pc", pc, 32'h200);
      nop(3);
      chk("slow_fetch_pc", pc, 32'h204);

      jr_to(32'h40);
      do_instr(32'h1022_FFFE, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'd0);
      chk("beq_taken", pc, 32'h3C);
      jr_to(32'h40);
      do_instr(32'h1422_FFFE, 0, 0, 0, 0, 0, 1, 1, 1, 0, 32'd0);
      chk("bne_not_taken", pc, 32'h44);
      do_instr(32'h1000_FFFF, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'd0);
      chk("self_loop", pc, 32'h44);
      do_instr(32'h1000_0010, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'd0);
      chk("branch_nt", pc, 32'h48);

      jr_to(32'h8000_0010);
      do_instr(32'h0800_0100, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'd0);
      chk("jump_pc", pc, 32'h8000_0400);
      jr_to(32'h0000_1003);
      chk("jr_mis_pc", pc, 32'h1000);
      chk("jr_mis_err", addr_err, 1);
      for (int i = 0; i < 5; i++) nop(0);
      chk("err_sticky", addr_err, 1);

      do_instr(32'h4501_0004, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'd0);
      chk("bc1t_taken", pc, 32'h1028);
      do_instr(32'h4500_0004, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'd0);
      chk("bc1f_nt", pc, 32'h102C);

      do_instr(32'h0123_4567, 1, 5, 0, 0, 0, 0, 0, 0, 0, 32'd0);
      chk("stall_pc", pc, 32'h1030);
      chk("stall_retired", retired, 22);

      // Reset during a pending fetch; a ready arriving under reset is dropped.
      imem.imem_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      imem.imem_ready = 1'b1;
      imem.imem_rdata = 32'hFACE_FACE;
      m_req = 1'b0;
      @(posedge clk); #1;
      m_pc = RPC; m_instr = 32'd0; m_retired = 32'd0; m_addr_err = 1'b0;
      chk("rst_mid_pc", pc, 32'h100);
      chk("rst_mid_retired", retired, 0);
      chk("rst_mid_instr", instr, 0);
      rst = 1'b0;
      imem.imem_ready = 1'b0;
      m_req = 1'b1;
      do_instr(32'h0000_0020, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0);
      chk("post_rst_pc", pc, 32'h104);
      chk("post_rst_retired", retired, 1);

      @(posedge clk); #1;
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
